// File: rtl/rng_bounded_sampler.sv
`default_nettype none
// ============================================================================
// Module   : rng_bounded_sampler
// Function : Draws 32-bit words from an upstream RNG and returns an unbiased
//            integer in [0, bound) by mask-and-reject sampling.
//            Optional statistics counters: define RNG_SAMPLER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rng_bounded_sampler #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    // bound request
    input  logic              req_valid,
    input  logic [31:0]       req_bound,
    output logic              req_ready,
    // upstream RNG words
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    // ranged sample
    output logic              out_valid,
    output logic [31:0]       out_data,
    input  logic              out_ready,
    // statistics
    output logic [STAT_W-1:0] rej_count,
    output logic [STAT_W-1:0] req_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MASK = 2'd1,
        DRAW = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] bound_q, bound_d;
    logic [31:0] mask_q,  mask_d;
    logic [31:0] data_q,  data_d;

    logic [31:0] w_bound_m1;
    logic [31:0] w_smear;
    logic [31:0] w_cand;
    logic        w_accept;
    logic        w_req_fire;
    logic        w_in_fire;
    logic        w_out_fire;

    // Handshake outputs decode registered state only; reset forces them low
    // so nothing is accepted or consumed in a reset cycle.
    assign req_ready = (state_q == IDLE) && !rst;
    assign in_ready  = (state_q == DRAW) && !rst;
    assign out_valid = (state_q == OUT)  && !rst;
    assign out_data  = data_q;

    assign w_req_fire = req_valid && req_ready;
    assign w_in_fire  = in_valid  && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // Right-smear of bound-1: bound=0 wraps to all ones, bound=1 gives zero.
    always_comb begin
        w_bound_m1 = bound_q - 32'd1;
        w_smear    = w_bound_m1;
        w_smear    = w_smear | (w_smear >> 1);
        w_smear    = w_smear | (w_smear >> 2);
        w_smear    = w_smear | (w_smear >> 4);
        w_smear    = w_smear | (w_smear >> 8);
        w_smear    = w_smear | (w_smear >> 16);
    end

    assign w_cand   = in_data & mask_q;
    assign w_accept = (bound_q == 32'd0) || (w_cand < bound_q);

    always_comb begin
        state_d = state_q;
        bound_d = bound_q;
        mask_d  = mask_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (w_req_fire) begin
                    bound_d = req_bound;
                    state_d = MASK;
                end
            end
            MASK: begin
                mask_d  = w_smear;
                state_d = DRAW;
            end
            DRAW: begin
                if (w_in_fire && w_accept) begin
                    data_d  = w_cand;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (w_out_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bound_q <= 32'd0;
            mask_q  <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            bound_q <= bound_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
        end
    end

`ifdef RNG_SAMPLER_STATS_EN
    logic [STAT_W-1:0] rej_q, rej_d;
    logic [STAT_W-1:0] cnt_q, cnt_d;
    logic              w_rej_fire;

    assign w_rej_fire = w_in_fire && !w_accept;

    // Both counters hold at all-ones rather than wrapping.
    always_comb begin
        rej_d = rej_q;
        cnt_d = cnt_q;
        if (w_rej_fire && (rej_q != {STAT_W{1'b1}})) begin
            rej_d = rej_q + {{(STAT_W-1){1'b0}}, 1'b1};
        end
        if (w_out_fire && (cnt_q != {STAT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rej_q <= {STAT_W{1'b0}};
            cnt_q <= {STAT_W{1'b0}};
        end else begin
            rej_q <= rej_d;
            cnt_q <= cnt_d;
        end
    end

    assign rej_count = rej_q;
    assign req_count = cnt_q;
`else
    assign rej_count = {STAT_W{1'b0}};
    assign req_count = {STAT_W{1'b0}};
`endif

endmodule
`default_nettype wire
